// File: rtl/video_out_if.sv
// Video bundle between the colour mixer and the VGA pins.
// Source side drives raw colour/sync/blank; sink side returns the final signals.
interface video_out_if;
  logic [5:0] r_in;
  logic [5:0] g_in;
  logic [5:0] b_in;
  logic       hsync_in;
  logic       vsync_in;
  logic       hblank_in;
  logic       vblank_in;
  logic [5:0] VGA_R;
  logic [5:0] VGA_G;
  logic [5:0] VGA_B;
  logic       HSync;
  logic       VSync;
  logic       HBlank;
  logic       VBlank;

  modport master (
    output r_in, g_in, b_in,
    output hsync_in, vsync_in,
    output hblank_in, vblank_in,
    input  VGA_R, VGA_G, VGA_B,
    input  HSync, VSync, HBlank, VBlank
  );

  modport slave (
    input  r_in, g_in, b_in,
    input  hsync_in, vsync_in,
    input  hblank_in, vblank_in,
    output VGA_R, VGA_G, VGA_B,
    output HSync, VSync, HBlank, VBlank
  );
endinterface

// File: rtl/video_out_stage.sv
// VGA output stage: 2-cycle pipeline, sync polarity detection, line count.
// Optional scanline dimming is built when VIDEO_SCANLINE_EN is defined.
module video_out_stage #(
  parameter int CE_DIV = 2,
  parameter int CNT_W  = 12
) (
  input  logic       clk_vga,
  input  logic       reset,
  video_out_if.slave vid,
  input  logic       scanline_on,
  output logic       ce_pix,
  output logic       hpol,
  output logic       vpol,
  output logic [9:0] lines_per_frame,
  output logic       pal
);
  localparam int PW = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [PW-1:0] PIX_LAST = PW'(CE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [9:0] V_MAX = '1;

  logic [PW-1:0]    pix_cnt;
  logic [5:0]       s1_r, s1_g, s1_b;
  logic             s1_hs, s1_vs, s1_hb, s1_vb;
  logic [5:0]       c_r, c_g, c_b;
  logic             blank, hs_norm, vs_norm;
  logic             hs_edge, vs_edge;
  logic [CNT_W-1:0] hi_cnt, lo_cnt, hi_len, lo_len;
  logic [9:0]       v_hi_cnt, v_lo_cnt, v_hi_len, v_lo_len;
  logic [9:0]       line_cnt;

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      pix_cnt <= '0;
      ce_pix  <= 1'b0;
    end else begin
      ce_pix  <= (pix_cnt == '0);
      pix_cnt <= (pix_cnt == PIX_LAST) ? '0 : pix_cnt + PW'(1);
    end
  end

`ifdef VIDEO_SCANLINE_EN
  logic dim;
  assign dim = scanline_on & line_cnt[0];
  assign c_r = dim ? (s1_r >> 1) : s1_r;
  assign c_g = dim ? (s1_g >> 1) : s1_g;
  assign c_b = dim ? (s1_b >> 1) : s1_b;
`else
  logic unused_scanline;
  assign unused_scanline = scanline_on;
  assign c_r = s1_r;
  assign c_g = s1_g;
  assign c_b = s1_b;
`endif

  assign blank   = s1_hb | s1_vb;
  assign hs_norm = s1_hs ~^ hpol;
  assign vs_norm = s1_vs ~^ vpol;
  assign hs_edge = hs_norm & ~vid.HSync;
  assign vs_edge = vs_norm & ~vid.VSync;
  assign pal     = lines_per_frame > 10'd287;

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      {s1_r, s1_g, s1_b} <= '0;
      {s1_hs, s1_vs, s1_hb, s1_vb} <= '0;
      vid.VGA_R  <= '0;
      vid.VGA_G  <= '0;
      vid.VGA_B  <= '0;
      vid.HSync  <= 1'b0;
      vid.VSync  <= 1'b0;
      vid.HBlank <= 1'b0;
      vid.VBlank <= 1'b0;
    end else begin
      s1_r  <= vid.r_in;
      s1_g  <= vid.g_in;
      s1_b  <= vid.b_in;
      s1_hs <= vid.hsync_in;
      s1_vs <= vid.vsync_in;
      s1_hb <= vid.hblank_in;
      s1_vb <= vid.vblank_in;
      vid.VGA_R  <= blank ? 6'd0 : c_r;
      vid.VGA_G  <= blank ? 6'd0 : c_g;
      vid.VGA_B  <= blank ? 6'd0 : c_b;
      vid.HSync  <= hs_norm;
      vid.VSync  <= vs_norm;
      vid.HBlank <= s1_hb;
      vid.VBlank <= s1_vb;
    end
  end

  // s1_hs doubles as the previous hsync_in level for edge detection
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      {hi_cnt, lo_cnt, hi_len, lo_len} <= '0;
      hpol <= 1'b0;
    end else if (vid.hsync_in) begin
      if (!s1_hs) begin
        lo_len <= lo_cnt;
        hi_cnt <= CNT_W'(1);
        if (hi_len != lo_cnt) hpol <= hi_len < lo_cnt;
      end else if (hi_cnt != CNT_MAX) begin
        hi_cnt <= hi_cnt + CNT_W'(1);
      end
    end else begin
      if (s1_hs) begin
        hi_len <= hi_cnt;
        lo_cnt <= CNT_W'(1);
      end else if (lo_cnt != CNT_MAX) begin
        lo_cnt <= lo_cnt + CNT_W'(1);
      end
    end
  end

  // vsync periods are measured in lines, not clocks
  always_ff @(posedge clk_vga) begin
    if (reset) begin
      {v_hi_cnt, v_lo_cnt, v_hi_len, v_lo_len} <= '0;
      vpol <= 1'b0;
    end else if (vid.vsync_in) begin
      if (!s1_vs) begin
        v_lo_len <= v_lo_cnt;
        v_hi_cnt <= {9'd0, hs_edge};
        if (v_hi_len != v_lo_cnt) vpol <= v_hi_len < v_lo_cnt;
      end else if (hs_edge && v_hi_cnt != V_MAX) begin
        v_hi_cnt <= v_hi_cnt + 10'd1;
      end
    end else begin
      if (s1_vs) begin
        v_hi_len <= v_hi_cnt;
        v_lo_cnt <= {9'd0, hs_edge};
      end else if (hs_edge && v_lo_cnt != V_MAX) begin
        v_lo_cnt <= v_lo_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_vga) begin
    if (reset) begin
      line_cnt        <= '0;
      lines_per_frame <= '0;
    end else if (vs_edge) begin
      lines_per_frame <= line_cnt;
      line_cnt        <= '0;
    end else if (hs_edge && line_cnt != V_MAX) begin
      line_cnt <= line_cnt + 10'd1;
    end
  end
endmodule
